// File: rtl/mdu_iter_if.sv
// Request/result bundle between the CPU control path and the iterative multiply/divide unit.
// The control path is the master; the unit is the slave.
interface mdu_iter_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; MTHI/MTLO complete in one cycle.
// A request runs one bit per cycle on operand magnitudes, and the result signs are fixed up in a final cycle.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rstn,
   mdu_iter_if.slave  bus
);
   localparam int              CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [2:0]      OP_MULT  = 3'b000;
   localparam logic [2:0]      OP_MULTU = 3'b001;
   localparam logic [2:0]      OP_DIV   = 3'b010;
   localparam logic [2:0]      OP_DIVU  = 3'b011;
   localparam logic [2:0]      OP_MTHI  = 3'b100;
   localparam logic [2:0]      OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
      if (neg) begin
         cond_neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cond_neg_w = v;
      end
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
      if (neg) begin
         cond_neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cond_neg_2w = v;
      end
   endfunction

   state_t               state_r, state_nx_s;
   logic [CW-1:0]        cnt_r, cnt_nx_s;
   logic [2*WIDTH-1:0]   acc_r, acc_nx_s;
   logic [WIDTH-1:0]     opnd_r, opnd_nx_s;
   logic [WIDTH-1:0]     a_orig_r, a_orig_nx_s;
   logic                 is_div_r, is_div_nx_s;
   logic                 neg_lo_r, neg_lo_nx_s;
   logic                 neg_hi_r, neg_hi_nx_s;
   logic                 dz_r, dz_nx_s;
   logic                 busy_r, busy_nx_s;
   logic                 done_r, done_nx_s;
   logic [WIDTH-1:0]     hi_r, hi_nx_s;
   logic [WIDTH-1:0]     lo_r, lo_nx_s;

   logic                 sgn_op_s, sa_s, sb_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [2*WIDTH-1:0]   mul_acc_s;
   logic [WIDTH:0]       div_rsh_s, div_diff_s;
   logic [2*WIDTH-1:0]   div_acc_s;
   logic [2*WIDTH-1:0]   prod_fix_s;

   assign sgn_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign sa_s     = sgn_op_s & bus.a[WIDTH-1];
   assign sb_s     = sgn_op_s & bus.b[WIDTH-1];

   // Multiply keeps the multiplier in the low half and shifts the partial product in from the top.
   assign mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
   assign mul_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};

   // Restoring divide: remainder in the high half, quotient bits enter at the bottom; bit WIDTH of the difference is the borrow.
   assign div_rsh_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
   assign div_diff_s = div_rsh_s - {1'b0, opnd_r};
   assign div_acc_s  = div_diff_s[WIDTH] ? {div_rsh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

   assign prod_fix_s = cond_neg_2w(acc_r, neg_lo_r);

   // Next-state and next-register computation for the IDLE/CALC/FIX sequence.
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      acc_nx_s    = acc_r;
      opnd_nx_s   = opnd_r;
      a_orig_nx_s = a_orig_r;
      is_div_nx_s = is_div_r;
      neg_lo_nx_s = neg_lo_r;
      neg_hi_nx_s = neg_hi_r;
      dz_nx_s     = dz_r;
      busy_nx_s   = busy_r;
      done_nx_s   = 1'b0;
      hi_nx_s     = hi_r;
      lo_nx_s     = lo_r;

      case (state_r)
         ST_IDLE: begin
            busy_nx_s = 1'b0;
            if (bus.start) begin
               case (bus.op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_nx_s  = ST_CALC;
                     busy_nx_s   = 1'b1;
                     cnt_nx_s    = CNT_LOAD;
                     a_orig_nx_s = bus.a;
                     is_div_nx_s = bus.op[1];
                     neg_lo_nx_s = sa_s ^ sb_s;
                     dz_nx_s     = (bus.b == {WIDTH{1'b0}});
                     if (bus.op[1]) begin
                        acc_nx_s    = {{WIDTH{1'b0}}, cond_neg_w(bus.a, sa_s)};
                        opnd_nx_s   = cond_neg_w(bus.b, sb_s);
                        neg_hi_nx_s = sa_s;
                     end else begin
                        acc_nx_s    = {{WIDTH{1'b0}}, cond_neg_w(bus.b, sb_s)};
                        opnd_nx_s   = cond_neg_w(bus.a, sa_s);
                        neg_hi_nx_s = sa_s ^ sb_s;
                     end
                  end
                  OP_MTHI: hi_nx_s = bus.a;
                  OP_MTLO: lo_nx_s = bus.a;
                  default: state_nx_s = ST_IDLE;
               endcase
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            cnt_nx_s = cnt_r - CNT_ONE;
            if (is_div_r) begin
               acc_nx_s = div_acc_s;
            end else begin
               acc_nx_s = mul_acc_s;
            end
            if (cnt_r == CNT_ONE) begin
               state_nx_s = ST_FIX;
            end else begin
               state_nx_s = ST_CALC;
            end
         end
         ST_FIX: begin
            state_nx_s = ST_IDLE;
            busy_nx_s  = 1'b0;
            done_nx_s  = 1'b1;
            if (!is_div_r) begin
               hi_nx_s = prod_fix_s[2*WIDTH-1:WIDTH];
               lo_nx_s = prod_fix_s[WIDTH-1:0];
            end else if (dz_r) begin
               hi_nx_s = a_orig_r;
               lo_nx_s = {WIDTH{1'b1}};
            end else begin
               hi_nx_s = cond_neg_w(acc_r[2*WIDTH-1:WIDTH], neg_hi_r);
               lo_nx_s = cond_neg_w(acc_r[WIDTH-1:0], neg_lo_r);
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            busy_nx_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CW{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         opnd_r   <= {WIDTH{1'b0}};
         a_orig_r <= {WIDTH{1'b0}};
         is_div_r <= 1'b0;
         neg_lo_r <= 1'b0;
         neg_hi_r <= 1'b0;
         dz_r     <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
      end else begin
         state_r  <= state_nx_s;
         cnt_r    <= cnt_nx_s;
         acc_r    <= acc_nx_s;
         opnd_r   <= opnd_nx_s;
         a_orig_r <= a_orig_nx_s;
         is_div_r <= is_div_nx_s;
         neg_lo_r <= neg_lo_nx_s;
         neg_hi_r <= neg_hi_nx_s;
         dz_r     <= dz_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
         hi_r     <= hi_nx_s;
         lo_r     <= lo_nx_s;
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a reference model fills a scoreboard queue at issue time,
// and each scenario task pops and compares when done pulses.
module tb_mdu_iter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   mdu_iter_if #(.WIDTH(W)) bus ();
   mdu_iter #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] exp_q[$];
   logic [31:0] cur_hi, cur_lo;

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      int          sa, sb, q, rm;
      logic [63:0] r;
      sa = a;
      sb = b;
      case (op)
         3'b000: begin p = longint'($signed(a)) * longint'($signed(b)); r = p; end
         3'b001: r = {32'd0, a} * {32'd0, b};
         3'b010: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else begin q = sa / sb; rm = sa % sb; r = {rm, q}; end
         end
         3'b011: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op <= 3'b011) exp_q.push_back(model(op, a, b));
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 3'b111;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   task automatic wait_done(input int from, output int lat, output bit to);
      int i;
      i   = from;
      to  = 1'b1;
      lat = 0;
      while (to && i < 45) begin
         @(posedge clk);
         #1;
         i++;
         if (bus.done === 1'b1) begin
            lat = i;
            to  = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rstn      = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         n_bad++; $display("FAIL reset_flags: got busy/done=%b want 00", {bus.busy, bus.done});
      end
      n_cmp++;
      if ({bus.hi, bus.lo} !== 64'd0) begin
         n_bad++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
      end
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      rstn   = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mult();
      logic [2:0]  ops[4];
      logic [31:0] as[4], bs[4];
      logic [63:0] want;
      int          lat;
      bit          to;
      ops = '{3'b001, 3'b000, 3'b000, 3'b001};
      as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, $urandom, $urandom};
      bs  = '{32'hFFFF_FFFF, 32'h0000_0007, $urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
         start_op(ops[k], as[k], bs[k]);
         n_cmp++;
         if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL mult_busy[%0d]: got %b want 1", k, bus.busy);
         end
         wait_done(0, lat, to);
         n_cmp++;
         if (to || lat != 33) begin
            n_bad++; $display("FAIL mult_latency[%0d]: got %0d (timeout=%0d) want 33", k, lat, to);
         end
         want = exp_q.pop_front();
         n_cmp++;
         if ({bus.hi, bus.lo} !== want) begin
            n_bad++; $display("FAIL mult_result[%0d] op=%b a=%h b=%h: got %h want %h", k, ops[k], as[k], bs[k], {bus.hi, bus.lo}, want);
         end
         cur_hi = want[63:32];
         cur_lo = want[31:0];
         @(posedge clk);
         #1;
         n_cmp++;
         if ({bus.busy, bus.done} !== 2'b00) begin
            n_bad++; $display("FAIL mult_done_pulse[%0d]: got busy/done=%b want 00", k, {bus.busy, bus.done});
         end
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops[7];
      logic [31:0] as[7], bs[7];
      logic [63:0] want;
      int          lat;
      bit          to;
      ops = '{3'b010, 3'b011, 3'b010, 3'b011, 3'b010, 3'b010, 3'b011};
      as  = '{32'hFFFF_FFF9, 32'd7, 32'h0000_1234, 32'h0000_1234, 32'h8000_0000, $urandom, $urandom};
      bs  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, ($urandom | 32'd1), ($urandom_range(1000, 1))};
      for (int k = 0; k < 7; k++) begin
         start_op(ops[k], as[k], bs[k]);
         wait_done(0, lat, to);
         n_cmp++;
         if (to || lat != 33) begin
            n_bad++; $display("FAIL div_latency[%0d]: got %0d (timeout=%0d) want 33", k, lat, to);
         end
         want = exp_q.pop_front();
         n_cmp++;
         if ({bus.hi, bus.lo} !== want) begin
            n_bad++; $display("FAIL div_result[%0d] op=%b a=%h b=%h: got %h want %h", k, ops[k], as[k], bs[k], {bus.hi, bus.lo}, want);
         end
         cur_hi = want[63:32];
         cur_lo = want[31:0];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ignore();
      logic [63:0] want;
      int          lat, pulses;
      bit          to;
      start_op(3'b011, 32'd100, 32'd7);
      bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd3; bus.b = 32'd3;
      @(posedge clk); #1;
      bus.op = 3'b100; bus.a = 32'h0000_DEAD;
      @(posedge clk); #1;
      bus.op = 3'b110;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.hi, bus.lo} !== {1'b1, cur_hi, cur_lo}) begin
         n_bad++; $display("FAIL ignore_midcalc: got busy=%b hi/lo=%h want busy=1 hi/lo=%h", bus.busy, {bus.hi, bus.lo}, {cur_hi, cur_lo});
      end
      wait_done(3, lat, to);
      n_cmp++;
      if (to || lat != 33) begin
         n_bad++; $display("FAIL ignore_latency: got %0d (timeout=%0d) want 33", lat, to);
      end
      want = exp_q.pop_front();
      n_cmp++;
      if ({bus.hi, bus.lo} !== want) begin
         n_bad++; $display("FAIL ignore_result: got %h want %h", {bus.hi, bus.lo}, want);
      end
      cur_hi = want[63:32];
      cur_lo = want[31:0];
      pulses = 0;
      repeat (36) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++; $display("FAIL ignore_extra_done: got %0d pulses want 0", pulses);
      end
      bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h0000_BEEF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, cur_hi, cur_lo}) begin
         n_bad++; $display("FAIL ignore_op110: got %b %b %h want 0 0 %h", bus.busy, bus.done, {bus.hi, bus.lo}, {cur_hi, cur_lo});
      end
   endtask

   task automatic test_mtlo_mthi();
      bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, cur_hi, 32'd5}) begin
         n_bad++; $display("FAIL mtlo: got %b %b %h want 0 0 %h", bus.busy, bus.done, {bus.hi, bus.lo}, {cur_hi, 32'd5});
      end
      cur_lo = 32'd5;
      bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h0000_0ABC;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, 32'h0000_0ABC, cur_lo}) begin
         n_bad++; $display("FAIL mthi: got %b %b %h want 0 0 %h", bus.busy, bus.done, {bus.hi, bus.lo}, {32'h0000_0ABC, cur_lo});
      end
      cur_hi = 32'h0000_0ABC;
   endtask

   task automatic test_back_to_back();
      logic [63:0] want;
      int          lat;
      bit          to;
      start_op(3'b001, 32'd6, 32'd7);
      wait_done(0, lat, to);
      want = exp_q.pop_front();
      n_cmp++;
      if (to || {bus.hi, bus.lo} !== want) begin
         n_bad++; $display("FAIL b2b_first: got %h (timeout=%0d) want %h", {bus.hi, bus.lo}, to, want);
      end
      start_op(3'b011, 32'd100, 32'd9);
      n_cmp++;
      if ({bus.busy, bus.hi, bus.lo} !== {1'b1, want}) begin
         n_bad++; $display("FAIL b2b_accept: got busy=%b hi/lo=%h want busy=1 hi/lo=%h", bus.busy, {bus.hi, bus.lo}, want);
      end
      wait_done(0, lat, to);
      n_cmp++;
      if (to || lat != 33) begin
         n_bad++; $display("FAIL b2b_latency: got %0d (timeout=%0d) want 33", lat, to);
      end
      want = exp_q.pop_front();
      n_cmp++;
      if ({bus.hi, bus.lo} !== want) begin
         n_bad++; $display("FAIL b2b_second: got %h want %h", {bus.hi, bus.lo}, want);
      end
      cur_hi = want[63:32];
      cur_lo = want[31:0];
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int pulses;
      start_op(3'b010, 32'hFFFF_FF00, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      n_cmp++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
         n_bad++; $display("FAIL reset_mid: got %b %b %h want 0 0 0", bus.busy, bus.done, {bus.hi, bus.lo});
      end
      rstn   = 1'b1;
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses != 0 || {bus.hi, bus.lo} !== 64'd0) begin
         n_bad++; $display("FAIL reset_mid_after: got %0d busy/done cycles hi/lo=%h want 0 and 0", pulses, {bus.hi, bus.lo});
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_ignore();
      test_mtlo_mthi();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
